// File: rtl/alarm_event_monitor.sv
// ============================================================================
// Module  : alarm_event_monitor
// Purpose : Timestamps alarm-controller status changes into a show-ahead FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_event_monitor #(
   parameter int DEPTH = 8,
   parameter int TS_W  = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    ena,
   input  logic                    alarm_siren,
   input  logic                    is_armed,
   input  logic                    is_wait_delay,
   input  logic                    clear,
   input  logic                    rd_req,
   output logic                    evt_valid,
   output logic [TS_W+5:0]         evt_data,
   output logic [$clog2(DEPTH):0]  evt_count,
   output logic                    full,
   output logic                    overflow
);

   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam int ENTRY_W = TS_W + 6;
   localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

   logic [2:0]         w_status;
   logic               w_empty;
   logic               w_full;
   logic               w_event;
   logic               w_pop;
   logic               w_wr;
   logic               w_drop;

   logic [2:0]         r_prev;
   logic [TS_W-1:0]    r_ts;
   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               r_overflow;

   assign w_status = {alarm_siren, is_armed, is_wait_delay};
   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == C_DEPTH);

   // clear takes priority: a concurrent event or pop is discarded
   assign w_event  = ena & (w_status != r_prev) & ~clear;
   assign w_pop    = rd_req & ~w_empty & ~clear;
   assign w_wr     = w_event & (~w_full | w_pop);
   assign w_drop   = w_event & w_full & ~w_pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev     <= 3'b000;
         r_ts       <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (clear) begin
         r_prev     <= w_status;
         r_ts       <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (ena) begin
            r_prev <= w_status;
            r_ts   <= r_ts + TS_W'(1);
         end
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Storage needs no reset; the pointers and count alone decide visibility
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= {r_ts, w_status, w_status ^ r_prev};
      end
   end

   assign evt_valid = ~w_empty;
   assign evt_data  = r_mem[r_rd_ptr];
   assign evt_count = r_count;
   assign full      = w_full;
   assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_alarm_event_monitor.sv
// ============================================================================
// Module  : tb_alarm_event_monitor
// Purpose : Scoreboard bench for alarm_event_monitor (TS_W=16 and TS_W=4 copies).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alarm_event_monitor;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ena;
   logic        alarm_siren;
   logic        is_armed;
   logic        is_wait_delay;
   logic        clear;
   logic        rd_req;

   logic        evt_valid,  evt_valid4;
   logic [21:0] evt_data;
   logic [9:0]  evt_data4;
   logic [3:0]  evt_count,  evt_count4;
   logic        full,       full4;
   logic        overflow,   overflow4;

   int          n_checks = 0;
   int          n_err    = 0;

   logic [21:0] q [$];
   logic [15:0] m_ts;
   logic [2:0]  m_prev;
   int          m_cnt;
   logic        m_ovf;

   always #5 clk = ~clk;

   alarm_event_monitor #(.DEPTH(8), .TS_W(16)) u_dut (
      .clk(clk), .reset_n(reset_n), .ena(ena), .alarm_siren(alarm_siren),
      .is_armed(is_armed), .is_wait_delay(is_wait_delay), .clear(clear),
      .rd_req(rd_req), .evt_valid(evt_valid), .evt_data(evt_data),
      .evt_count(evt_count), .full(full), .overflow(overflow)
   );

   alarm_event_monitor #(.DEPTH(8), .TS_W(4)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .ena(ena), .alarm_siren(alarm_siren),
      .is_armed(is_armed), .is_wait_delay(is_wait_delay), .clear(clear),
      .rd_req(rd_req), .evt_valid(evt_valid4), .evt_data(evt_data4),
      .evt_count(evt_count4), .full(full4), .overflow(overflow4)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: whenever the DUT is about to pop, its head must match the scoreboard
   always @(negedge clk) begin
      if (reset_n && evt_valid && rd_req && !clear) begin
         if (q.size() == 0) begin
            chk("pop_unexpected", 32'd1, 32'd0);
         end else begin
            logic [21:0] e;
            e = q.pop_front();
            chk("pop_data", 32'(evt_data), 32'(e));
            chk("pop_data_ts4", 32'(evt_data4), 32'({e[9:6], e[5:0]}));
            chk("pop_valid_ts4", 32'(evt_valid4), 32'd1);
         end
      end
   end

   task automatic cyc(input logic [2:0] st, input logic en, input logic rd, input logic clr);
      logic pop, evt, wr;
      {alarm_siren, is_armed, is_wait_delay} = st;
      ena    = en;
      rd_req = rd;
      clear  = clr;
      pop = rd && (m_cnt > 0) && !clr;
      evt = en && (st != m_prev) && !clr;
      wr  = evt && ((m_cnt < 8) || pop);
      if (clr) begin
         m_cnt  = 0;
         m_ts   = 16'd0;
         m_ovf  = 1'b0;
         m_prev = st;
      end else begin
         if (wr) q.push_back({m_ts, st, st ^ m_prev});
         if (evt && !wr) m_ovf = 1'b1;
         m_cnt = m_cnt + (wr ? 1 : 0) - (pop ? 1 : 0);
         if (en) begin
            m_prev = st;
            m_ts   = m_ts + 16'd1;
         end
      end
      @(posedge clk);
      if (clr) q.delete();
      #1;
      chk("count",     32'(evt_count),  32'(m_cnt));
      chk("count_ts4", 32'(evt_count4), 32'(m_cnt));
      chk("valid",     32'(evt_valid),  32'(m_cnt > 0));
      chk("full",      32'(full),       32'(m_cnt == 8));
      chk("full_ts4",  32'(full4),      32'(m_cnt == 8));
      chk("overflow",  32'(overflow),   32'(m_ovf));
      chk("overflow_ts4", 32'(overflow4), 32'(m_ovf));
   endtask

   task automatic reset_model();
      q.delete();
      m_ts   = 16'd0;
      m_prev = 3'b000;
      m_cnt  = 0;
      m_ovf  = 1'b0;
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_valid"},    32'(evt_valid),  32'd0);
      chk({nm, "_count"},    32'(evt_count),  32'd0);
      chk({nm, "_full"},     32'(full),       32'd0);
      chk({nm, "_overflow"}, 32'(overflow),   32'd0);
      chk({nm, "_count4"},   32'(evt_count4), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0;
      ena = 1'b0; alarm_siren = 1'b0; is_armed = 1'b0; is_wait_delay = 1'b0;
      clear = 1'b0; rd_req = 1'b0;
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;

      // Quiet start with status 000: no event; then is_armed rises at ts=5
      for (int i = 0; i < 5; i++) cyc(3'b000, 1'b1, 1'b0, 1'b0);
      cyc(3'b010, 1'b1, 1'b0, 1'b0);
      chk("first_evt_data",     32'(evt_data),  32'({16'd5, 3'b010, 3'b010}));
      chk("first_evt_data_ts4", 32'(evt_data4), 32'({4'd5, 3'b010, 3'b010}));
      cyc(3'b111, 1'b1, 1'b0, 1'b0);

      // ena low with toggling inputs: nothing recorded, timestamp frozen at 7
      for (int i = 0; i < 10; i++) cyc((i % 2 == 0) ? 3'b101 : 3'b000, 1'b0, 1'b0, 1'b0);
      cyc(3'b011, 1'b1, 1'b0, 1'b0);
      cyc(3'b011, 1'b0, 1'b1, 1'b0);
      chk("second_evt_data", 32'(evt_data), 32'({16'd6, 3'b111, 3'b101}));
      cyc(3'b011, 1'b0, 1'b1, 1'b0);
      chk("frozen_ts_data",  32'(evt_data), 32'({16'd7, 3'b011, 3'b100}));
      cyc(3'b011, 1'b0, 1'b1, 1'b0);
      cyc(3'b011, 1'b0, 1'b1, 1'b0);

      // Nine events with no reads: eighth fills, ninth is dropped
      for (int i = 0; i < 9; i++) cyc((i % 2 == 0) ? 3'b010 : 3'b011, 1'b1, 1'b0, 1'b0);
      chk("ovf_set",      32'(overflow), 32'd1);
      chk("full_head",    32'(evt_data), 32'({16'd8, 3'b010, 3'b001}));
      for (int i = 0; i < 8; i++) cyc(3'b010, 1'b0, 1'b1, 1'b0);
      chk("drained_valid", 32'(evt_valid), 32'd0);
      chk("ovf_sticky",    32'(overflow),  32'd1);

      cyc(3'b010, 1'b0, 1'b0, 1'b1);
      chk("ovf_cleared", 32'(overflow), 32'd0);

      // Full FIFO with simultaneous event and pop: no drop
      for (int i = 0; i < 8; i++) cyc((i % 2 == 0) ? 3'b011 : 3'b010, 1'b1, 1'b0, 1'b0);
      cyc(3'b011, 1'b1, 1'b1, 1'b0);
      chk("full_push_pop_count", 32'(evt_count), 32'd8);
      chk("full_push_pop_ovf",   32'(overflow),  32'd0);
      for (int i = 0; i < 8; i++) cyc(3'b011, 1'b0, 1'b1, 1'b0);

      // Empty FIFO with simultaneous event and pop: write only
      cyc(3'b001, 1'b1, 1'b1, 1'b0);
      chk("empty_push_pop_count", 32'(evt_count), 32'd1);
      chk("empty_push_pop_data",  32'(evt_data),  32'({16'd9, 3'b001, 3'b010}));

      // Timestamp wrap in the 4-bit copy: 15 then 0
      cyc(3'b001, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 15; i++) cyc(3'b001, 1'b1, 1'b0, 1'b0);
      cyc(3'b101, 1'b1, 1'b0, 1'b0);
      cyc(3'b100, 1'b1, 1'b0, 1'b0);
      chk("wrap_head_ts4", 32'(evt_data4), 32'({4'd15, 3'b101, 3'b100}));
      cyc(3'b100, 1'b0, 1'b1, 1'b0);
      chk("wrap_next_ts4", 32'(evt_data4), 32'({4'd0, 3'b100, 3'b001}));
      chk("wrap_next_ts16", 32'(evt_data), 32'({16'd16, 3'b100, 3'b001}));

      // Clear with a pending event and pop, then a fresh event at ts=0
      cyc(3'b111, 1'b1, 1'b1, 1'b1);
      chk("clear_count", 32'(evt_count), 32'd0);
      cyc(3'b110, 1'b1, 1'b0, 1'b0);
      chk("post_clear_data", 32'(evt_data), 32'({16'd0, 3'b110, 3'b001}));
      cyc(3'b010, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset mid-operation discards everything
      ena = 1'b0; rd_req = 1'b0; clear = 1'b0;
      {alarm_siren, is_armed, is_wait_delay} = 3'b000;
      #2 reset_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      reset_model();
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      cyc(3'b101, 1'b1, 1'b0, 1'b0);
      chk("post_reset_data", 32'(evt_data), 32'({16'd0, 3'b101, 3'b101}));
      cyc(3'b101, 1'b0, 1'b1, 1'b0);

      chk("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alarm_event_monitor.md
ALARM_EVENT_MONITOR -- requirements
Module: alarm_event_monitor

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
REQ-002 Parameter TS_W, default 16, timestamp counter width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 ena  input  1  sample enable; monitor and timestamp advance only when 1.
REQ-006 alarm_siren  input  1  alarm controller siren output.
REQ-007 is_armed  input  1  alarm controller armed status.
REQ-008 is_wait_delay  input  1  alarm controller entry/exit delay status.
REQ-009 clear  input  1  synchronous flush of FIFO, timestamp and overflow.
REQ-010 rd_req  input  1  pop request, one entry per cycle.
REQ-011 evt_valid  output  1  head entry present (FIFO not empty).
REQ-012 evt_data  output  TS_W+6  head entry {timestamp, new_status[2:0], change_mask[2:0]}.
REQ-013 evt_count  output  $clog2(DEPTH)+1  entries stored, 0..DEPTH.
REQ-014 full  output  1  evt_count == DEPTH.
REQ-015 overflow  output  1  sticky: an event was dropped.

Function
REQ-016 Status vector SHALL be status = {alarm_siren, is_armed, is_wait_delay}.
REQ-017 Register prev_status SHALL load status on every edge with ena=1; hold when ena=0.
REQ-018 Event SHALL be detected in a cycle with ena=1 and status != prev_status; change_mask = status XOR prev_status.
REQ-019 Timestamp counter ts SHALL increment by 1 per cycle with ena=1, wrap 2^TS_W-1 -> 0, hold when ena=0.
REQ-020 Entry written SHALL be {ts value before the edge, status, change_mask}.
REQ-021 Latency: input change sampled at edge N SHALL appear (evt_valid=1 if FIFO was empty) after edge N, i.e. 1 cycle.
REQ-022 FIFO SHALL be show-ahead: evt_data shows the oldest entry whenever evt_valid=1; evt_data undefined-but-stable (hold last) when empty.
REQ-023 rd_req=1 with evt_valid=1 SHALL pop the head at that edge; rd_req with evt_valid=0 SHALL be ignored.
REQ-024 Event with FIFO full and no pop SHALL be dropped and overflow set to 1; FIFO contents unchanged.
REQ-025 Event and pop in same cycle with FIFO full SHALL both occur (no drop), evt_count stays DEPTH.
REQ-026 Event and pop in same cycle with FIFO empty SHALL write only (pop ignored), evt_count 0 -> 1.
REQ-027 Pointers SHALL wrap modulo DEPTH; evt_count SHALL be exact across wrap.
REQ-028 overflow SHALL clear only by clear or reset.
REQ-029 clear=1 SHALL, at that edge: empty FIFO, ts <- 0, overflow <- 0, prev_status <- status; concurrent event and rd_req are discarded.
REQ-030 ena=0 SHALL NOT block rd_req pops or clear.

Reset
REQ-031 reset_n=0 SHALL immediately force evt_valid=0, evt_count=0, full=0, overflow=0, ts=0, prev_status=3'b000, pointers=0.
REQ-032 First ena cycle after reset with status=3'b000 SHALL record no event; any nonzero status SHALL record an event with mask = status.
REQ-033 Reset asserted mid-operation SHALL discard all stored entries; no partial write survives.

Verification
REQ-034 Reset, ena=1, is_armed 0->1 at ts=5 -> one cycle later evt_valid=1, evt_data={16'd5, 3'b010, 3'b010}, evt_count=1.
REQ-035 Siren and wait_delay toggle together from 3'b010 -> entry status 3'b111, mask 3'b101; ena=0 for 10 cycles with toggling inputs -> no entries, ts frozen.
REQ-036 Generate 9 events, no reads, DEPTH=8 -> full=1, evt_count=8, overflow=1, head = first event; 8 pops return events 1..8 in order then evt_valid=0.
REQ-037 FIFO full, event and rd_req same cycle -> evt_count stays 8, overflow stays 0, newest entry at tail; rd_req while empty -> no change.
REQ-038 TS_W=4, event at ts=15 and next at ts=0 after wrap -> timestamps 15 then 0; clear with pending event and rd_req -> evt_count=0, ts=0, overflow=0, no entry written.
